// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates ICache and DCache requests onto one line-wide memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate on ties; when undefined, DCache wins every tie.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              ic_valid_req_i,
    output logic              ic_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_valid_req_i,
    input  logic              dc_we_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_ready_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_valid_req_o,
    output logic              mem_we_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

    state_t            state_q;
    logic              ic_pend_q;
    logic              ic_stale_q;
    logic [ADDR_W-1:0] ic_addr_q;
    logic              dc_pend_q;
    logic              dc_we_q;
    logic [ADDR_W-1:0] dc_addr_q;
    logic [LINE_W-1:0] dc_wdata_q;

    logic              ic_want;
    logic              dc_want;
    logic              tie_to_d;
    logic              grant_d;
    logic              grant_i;
    logic [ADDR_W-1:0] ic_addr_eff;
    logic [ADDR_W-1:0] dc_addr_eff;
    logic              dc_we_eff;
    logic [LINE_W-1:0] dc_wdata_eff;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    assign tie_to_d = ~last_d_q;
`else
    assign tie_to_d = 1'b1;
`endif

    // Incoming pulses bypass the pending registers so an idle arbiter issues next cycle.
    // A new I pulse supersedes a pending one; a new D pulse never replaces a pending one.
    always_comb begin
        ic_want      = ic_pend_q | ic_valid_req_i;
        dc_want      = dc_pend_q | dc_valid_req_i;
        ic_addr_eff  = ic_valid_req_i ? ic_addr_i : ic_addr_q;
        dc_addr_eff  = dc_pend_q ? dc_addr_q : dc_addr_i;
        dc_we_eff    = dc_pend_q ? dc_we_q : dc_we_i;
        dc_wdata_eff = dc_pend_q ? dc_wdata_q : dc_wdata_i;
        grant_d      = dc_want & (~ic_want | tie_to_d);
        grant_i      = ic_want & ~grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ic_pend_q       <= 1'b0;
            ic_stale_q      <= 1'b0;
            ic_addr_q       <= '0;
            dc_pend_q       <= 1'b0;
            dc_we_q         <= 1'b0;
            dc_addr_q       <= '0;
            dc_wdata_q      <= '0;
            ic_ready_o      <= 1'b0;
            ic_data_o       <= '0;
            dc_ready_o      <= 1'b0;
            dc_rdata_o      <= '0;
            mem_addr_o      <= '0;
            mem_valid_req_o <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_wdata_o     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q        <= 1'b0;
`endif
        end else begin
            mem_valid_req_o <= 1'b0;
            ic_ready_o      <= 1'b0;
            dc_ready_o      <= 1'b0;

            if (ic_valid_req_i) begin
                ic_pend_q <= 1'b1;
                ic_addr_q <= ic_addr_i;
            end
            if (dc_valid_req_i && !dc_pend_q && state_q != WAIT_D) begin
                dc_pend_q  <= 1'b1;
                dc_addr_q  <= dc_addr_i;
                dc_we_q    <= dc_we_i;
                dc_wdata_q <= dc_wdata_i;
            end

            case (state_q)
                IDLE: begin
                    // The clears below override the captures above: a granted pulse is consumed.
                    if (grant_d) begin
                        mem_valid_req_o <= 1'b1;
                        mem_addr_o      <= dc_addr_eff & LINE_MASK;
                        mem_we_o        <= dc_we_eff;
                        mem_wdata_o     <= dc_wdata_eff;
                        dc_pend_q       <= 1'b0;
                        state_q         <= WAIT_D;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q        <= 1'b1;
`endif
                    end else if (grant_i) begin
                        mem_valid_req_o <= 1'b1;
                        mem_addr_o      <= ic_addr_eff & LINE_MASK;
                        mem_we_o        <= 1'b0;
                        mem_wdata_o     <= '0;
                        ic_pend_q       <= 1'b0;
                        state_q         <= WAIT_I;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q        <= 1'b0;
`endif
                    end
                end
                WAIT_I: begin
                    if (ic_valid_req_i) begin
                        ic_stale_q <= 1'b1;
                    end
                    // A newer I request makes the in-flight line stale; swallow its response.
                    if (mem_ready_i) begin
                        state_q    <= IDLE;
                        ic_stale_q <= 1'b0;
                        if (!ic_stale_q && !ic_valid_req_i) begin
                            ic_ready_o <= 1'b1;
                            ic_data_o  <= mem_data_i;
                        end
                    end
                end
                WAIT_D: begin
                    if (mem_ready_i) begin
                        state_q    <= IDLE;
                        dc_ready_o <= 1'b1;
                        if (!mem_we_o) begin
                            dc_rdata_o <= mem_data_i;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ic_addr_i;
    logic          ic_valid_req_i;
    logic          ic_ready_o;
    logic [LW-1:0] ic_data_o;
    logic [AW-1:0] dc_addr_i;
    logic          dc_valid_req_i;
    logic          dc_we_i;
    logic [LW-1:0] dc_wdata_i;
    logic          dc_ready_o;
    logic [LW-1:0] dc_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_valid_req_o;
    logic          mem_we_o;
    logic [LW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic [LW-1:0] mem_data_i;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_addr_i(ic_addr_i), .ic_valid_req_i(ic_valid_req_i),
        .ic_ready_o(ic_ready_o), .ic_data_o(ic_data_o),
        .dc_addr_i(dc_addr_i), .dc_valid_req_i(dc_valid_req_i), .dc_we_i(dc_we_i),
        .dc_wdata_i(dc_wdata_i), .dc_ready_o(dc_ready_o), .dc_rdata_o(dc_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_valid_req_o(mem_valid_req_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wdata;
    } mreq_t;

    mreq_t         exp_mem[$];
    logic [LW-1:0] exp_ic[$];
    logic [LW-1:0] exp_dc[$];
    mreq_t         m;
    logic [LW-1:0] d;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ic(input logic [AW-1:0] a);
        ic_addr_i = a;
        ic_valid_req_i = 1'b1;
        tick();
        ic_valid_req_i = 1'b0;
    endtask

    task automatic pulse_dc(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] wd);
        dc_addr_i = a;
        dc_we_i = we;
        dc_wdata_i = wd;
        dc_valid_req_i = 1'b1;
        tick();
        dc_valid_req_i = 1'b0;
    endtask

    task automatic respond(input logic [LW-1:0] data);
        mem_data_i = data;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        mem_data_i = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_valid"}, mem_valid_req_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_we"}, mem_we_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_ic_ready"}, ic_ready_o, 0);
        chk({tag, "_ic_data"}, ic_data_o, 0);
        chk({tag, "_dc_ready"}, dc_ready_o, 0);
        chk({tag, "_dc_rdata"}, dc_rdata_o, 0);
    endtask

    // Monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid_req_o) begin
                $display("mem req: addr=%h we=%0b", mem_addr_o, mem_we_o);
                if (exp_mem.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_req_unexpected: got addr %h, required no request", mem_addr_o);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", mem_addr_o, m.addr);
                    chk("mem_we", mem_we_o, m.we);
                    if (m.we) chk("mem_wdata", mem_wdata_o, m.wdata);
                end
            end
            if (ic_ready_o) begin
                $display("ic resp: data=%h", ic_data_o);
                if (exp_ic.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL ic_ready_unexpected: got data %h, required no response", ic_data_o);
                end else begin
                    d = exp_ic.pop_front();
                    chk("ic_data", ic_data_o, d);
                end
            end
            if (dc_ready_o) begin
                $display("dc resp: data=%h", dc_rdata_o);
                if (exp_dc.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL dc_ready_unexpected: got data %h, required no response", dc_rdata_o);
                end else begin
                    d = exp_dc.pop_front();
                    chk("dc_rdata", dc_rdata_o, d);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ic_addr_i = '0; ic_valid_req_i = 1'b0;
        dc_addr_i = '0; dc_valid_req_i = 1'b0; dc_we_i = 1'b0; dc_wdata_i = '0;
        mem_ready_i = 1'b0; mem_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single I read: one-cycle latency, low address bits forced to zero
        exp_mem.push_back('{32'h0000_1230, 1'b0, 128'h0});
        pulse_ic(32'h0000_1234);
        chk("lat_mem_valid", mem_valid_req_o, 1);
        tick(); tick();
        exp_ic.push_back({16{8'hA5}});
        respond({16{8'hA5}});
        chk("ic_ready_pulse", ic_ready_o, 1);
        tick();
        chk("ic_ready_one_cycle", ic_ready_o, 0);
        chk("ic_data_hold", ic_data_o, {16{8'hA5}});

        // Tie: D write wins, I issues one cycle after D completes
        exp_mem.push_back('{32'h2000, 1'b1, {16{8'h11}}});
        exp_mem.push_back('{32'h1000, 1'b0, 128'h0});
        ic_addr_i = 32'h1000; ic_valid_req_i = 1'b1;
        dc_addr_i = 32'h2000; dc_we_i = 1'b1; dc_wdata_i = {16{8'h11}}; dc_valid_req_i = 1'b1;
        tick();
        ic_valid_req_i = 1'b0; dc_valid_req_i = 1'b0; dc_we_i = 1'b0;
        chk("tie1_first_is_write", mem_we_o, 1);
        tick(); tick();
        exp_dc.push_back(128'h0);
        respond({16{8'hFF}});
        chk("tie1_gap", mem_valid_req_o, 0);
        tick();
        chk("tie1_i_issue", mem_valid_req_o, 1);
        tick();
        exp_ic.push_back({16{8'h5A}});
        respond({16{8'h5A}});
        tick();

        // D-only read, then a second tie
        exp_mem.push_back('{32'h2200, 1'b0, 128'h0});
        pulse_dc(32'h2200, 1'b0, 128'h0);
        tick();
        exp_dc.push_back({16{8'h33}});
        respond({16{8'h33}});
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_mem.push_back('{32'h1100, 1'b0, 128'h0});
        exp_mem.push_back('{32'h2100, 1'b0, 128'h0});
        exp_ic.push_back({16{8'h88}});
        exp_dc.push_back({16{8'h77}});
`else
        exp_mem.push_back('{32'h2100, 1'b0, 128'h0});
        exp_mem.push_back('{32'h1100, 1'b0, 128'h0});
        exp_dc.push_back({16{8'h77}});
        exp_ic.push_back({16{8'h88}});
`endif
        ic_addr_i = 32'h1100; ic_valid_req_i = 1'b1;
        dc_addr_i = 32'h2100; dc_we_i = 1'b0; dc_valid_req_i = 1'b1;
        tick();
        ic_valid_req_i = 1'b0; dc_valid_req_i = 1'b0;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        respond({16{8'h88}});
        tick(); tick();
        respond({16{8'h77}});
`else
        respond({16{8'h77}});
        tick(); tick();
        respond({16{8'h88}});
`endif
        tick();

        // Stale I: second pulse during WAIT_I swallows the first response
        exp_mem.push_back('{32'h100, 1'b0, 128'h0});
        exp_mem.push_back('{32'h200, 1'b0, 128'h0});
        pulse_ic(32'h100);
        pulse_ic(32'h200);
        tick();
        respond({8{16'hDEAD}});
        chk("stale_no_ready", ic_ready_o, 0);
        chk("stale_data_kept", ic_data_o, {16{8'h88}});
        tick();
        chk("stale_reissue", mem_valid_req_o, 1);
        tick();
        exp_ic.push_back({8{16'hBEEF}});
        respond({8{16'hBEEF}});
        chk("stale_new_ready", ic_ready_o, 1);
        tick();

        // Two I pulses during WAIT_D: only the newest issues
        exp_mem.push_back('{32'h2300, 1'b0, 128'h0});
        exp_mem.push_back('{32'h400, 1'b0, 128'h0});
        pulse_dc(32'h2300, 1'b0, 128'h0);
        pulse_ic(32'h300);
        pulse_ic(32'h400);
        tick();
        exp_dc.push_back({16{8'h44}});
        respond({16{8'h44}});
        tick();
        chk("newest_wins_issue", mem_valid_req_o, 1);
        tick();
        exp_ic.push_back({16{8'h55}});
        respond({16{8'h55}});
        tick();

        // Reset during WAIT_D, then a late memory response
        exp_mem.push_back('{32'h2400, 1'b0, 128'h0});
        pulse_dc(32'h2400, 1'b0, 128'h0);
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        mem_data_i = {16{8'h66}};
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        mem_data_i = '0;
        chk("rst_no_dc_ready", dc_ready_o, 0);
        chk("rst_no_issue", mem_valid_req_o, 0);
        chk("rst_dc_rdata", dc_rdata_o, 0);
        exp_mem.push_back('{32'h500, 1'b0, 128'h0});
        pulse_ic(32'h500);
        chk("post_rst_issue", mem_valid_req_o, 1);
        tick();
        exp_ic.push_back({16{8'h99}});
        respond({16{8'h99}});
        tick(); tick();

        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("ic_queue_drained", exp_ic.size(), 0);
        chk("dc_queue_drained", exp_dc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
